// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: default sizes, FSM state
// encoding, carry-in select codes and the carry-in mux helper.
package alu_issue_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned NREG_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CIN_ZERO = 2'b00;
    localparam logic [1:0] CIN_ONE  = 2'b01;
    localparam logic [1:0] CIN_FLAG = 2'b10;

    // Carry-in source select; the unused code 2'b11 behaves as CIN_ZERO.
    function automatic logic cin_select(input logic [1:0] sel, input logic flag);
        case (sel)
            CIN_ONE:  return 1'b1;
            CIN_FLAG: return flag;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Operand register file: NREG x WIDTH entries, async active-low reset,
// one write port and two combinational read ports.
//   clk, rst_n              clock / async reset
//   we, waddr, wdata        write port (arbitrated by the parent)
//   raddr_a/_b, rdata_a/b_c read ports (combinational)
module alu_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a_c,
    output logic [WIDTH-1:0] rdata_b_c
);

    logic [WIDTH-1:0] mem [NREG];

    // Storage with single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a_c = mem[raddr_a];
    assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for an 8-bit combinational ALU. Accepts instructions
// over valid/ready, drives registered operands/select/carry-in to the ALU,
// captures D/C_out/z one cycle later, writes the result back and updates
// sticky carry/zero flags.
//   clk, rst_n                         clock / async active-low reset
//   in_valid/in_ready, in_op, in_rd,
//   in_rs1, in_rs2, in_cin_sel          instruction handshake and fields
//   ld_en, ld_addr, ld_data             direct register load (only when ready)
//   alu_a, alu_b, alu_s, alu_cin        registered ALU drive
//   alu_d, alu_cout, alu_z              ALU result inputs
//   res_valid, res_data, res_cout,
//   res_z                               captured result and one-cycle strobe
//   flag_c, flag_z                      flags of last completed instruction
//   busy                                high while executing
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic [1:0]       in_cin_sel,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_d,
    input  logic             alu_cout,
    input  logic             alu_z,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_z,
    output logic             flag_c,
    output logic             flag_z,
    output logic             busy
);

    state_t           state;
    logic [AW-1:0]    rd_q;

    logic             accept_c;
    logic             ld_fire_c;
    logic             wb_c;
    logic             we_c;
    logic [AW-1:0]    waddr_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] rf_a_c;
    logic [WIDTH-1:0] rf_b_c;
    logic [WIDTH-1:0] opa_c;
    logic [WIDTH-1:0] opb_c;

    assign accept_c  = in_valid & in_ready;
    assign ld_fire_c = ld_en & in_ready;
    assign wb_c      = (state == EXEC);

    // Write-port arbitration: write-back only happens in EXEC, loads only
    // when ready (never in EXEC), so the two cannot collide.
    always_comb begin
        we_c    = ld_fire_c | wb_c;
        waddr_c = ld_addr;
        wdata_c = ld_data;
        if (wb_c) begin
            waddr_c = rd_q;
            wdata_c = alu_d;
        end
    end

    // Same-cycle load forwards into the operand being read.
    always_comb begin
        opa_c = rf_a_c;
        opb_c = rf_b_c;
        if (ld_fire_c && (ld_addr == in_rs1)) opa_c = ld_data;
        if (ld_fire_c && (ld_addr == in_rs2)) opb_c = ld_data;
    end

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .AW    (AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we_c),
        .waddr     (waddr_c),
        .wdata     (wdata_c),
        .raddr_a   (in_rs1),
        .raddr_b   (in_rs2),
        .rdata_a_c (rf_a_c),
        .rdata_b_c (rf_b_c)
    );

    // Issue FSM with registered ALU drive, result capture and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_cin   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_z     <= 1'b0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        alu_a    <= opa_c;
                        alu_b    <= opb_c;
                        alu_s    <= in_op;
                        alu_cin  <= cin_select(in_cin_sel, flag_c);
                        rd_q     <= in_rd;
                        state    <= EXEC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    res_data  <= alu_d;
                    res_cout  <= alu_cout;
                    res_z     <= alu_z;
                    flag_c    <= alu_cout;
                    flag_z    <= alu_z;
                    res_valid <= 1'b1;
                    state     <= DONE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: stub adder ALU, transaction-level
// reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic with occasional resets.
module tb_alu_issue_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREG  = 4;
    localparam int unsigned AW    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = '0;
    logic [AW-1:0]    in_rd = '0;
    logic [AW-1:0]    in_rs1 = '0;
    logic [AW-1:0]    in_rs2 = '0;
    logic [1:0]       in_cin_sel = '0;
    logic             ld_en = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [WIDTH-1:0] ld_data = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_d, res_data;
    logic [3:0]       alu_s;
    logic             alu_cin, alu_cout, alu_z;
    logic             res_valid, res_cout, res_z, flag_c, flag_z, busy;

    int checks = 0;
    int errors = 0;
    bit stop_cmp = 1'b0;

    always #5 clk = ~clk;

    // Stub ALU: D = A + B + C_in.
    logic [8:0] stub_sum;
    assign stub_sum = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
    assign alu_d    = stub_sum[7:0];
    assign alu_cout = stub_sum[8];
    assign alu_z    = (stub_sum[7:0] == 8'd0);

    alu_issue_ctrl #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_cin_sel(in_cin_sel),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_d(alu_d), .alu_cout(alu_cout), .alu_z(alu_z),
        .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout),
        .res_z(res_z), .flag_c(flag_c), .flag_z(flag_z), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] m_rf [4];
    logic [7:0] m_a, m_b, m_res;
    logic [3:0] m_s;
    logic       m_cin, m_cout, m_z, m_fc, m_fz, m_valid, m_inflight;
    logic [1:0] m_rd;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
        m_a = 0; m_b = 0; m_s = 0; m_cin = 0; m_res = 0; m_cout = 0; m_z = 0;
        m_fc = 0; m_fz = 0; m_valid = 0; m_inflight = 0; m_rd = 0;
    endtask

    // Advance the model by one clock using the inputs presented for that clock.
    task automatic model_step();
        logic [8:0] s;
        if (m_inflight) begin
            s = 9'(m_a) + 9'(m_b) + 9'(m_cin);
            m_rf[m_rd] = s[7:0];
            m_res = s[7:0]; m_cout = s[8]; m_z = (s[7:0] == 8'd0);
            m_fc = m_cout; m_fz = m_z;
            m_valid = 1'b1;
            m_inflight = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (ld_en) m_rf[ld_addr] = ld_data;
            if (in_valid) begin
                m_a = m_rf[in_rs1];
                m_b = m_rf[in_rs2];
                m_s = in_op;
                m_cin = (in_cin_sel == 2'd1) ? 1'b1 : (in_cin_sel == 2'd2) ? m_fc : 1'b0;
                m_rd = in_rd;
                m_inflight = 1'b1;
            end
        end
    endtask

    // Compare process: every falling edge, DUT outputs vs model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            if (!stop_cmp) begin
                chk("m_in_ready", in_ready, !m_inflight);
                chk("m_busy", busy, m_inflight);
                chk("m_res_valid", res_valid, m_valid);
                chk("m_alu_a", alu_a, m_a);
                chk("m_alu_b", alu_b, m_b);
                chk("m_alu_s", alu_s, m_s);
                chk("m_alu_cin", alu_cin, m_cin);
                chk("m_res_data", res_data, m_res);
                chk("m_res_cout", res_cout, m_cout);
                chk("m_res_z", res_z, m_z);
                chk("m_flag_c", flag_c, m_fc);
                chk("m_flag_z", flag_z, m_fz);
            end
            if (rst_n) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d; in_valid = 1'b0;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic set_instr(input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic [1:0] rd, input logic [1:0] cs);
        in_valid = 1'b1; in_op = 4'd0; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_cin_sel = cs;
    endtask

    int pulses;
    int ready_low;

    initial begin
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        tick();

        // 1: 81 + 80 + 1
        load(2'd0, 8'd81);
        load(2'd1, 8'd80);
        set_instr(2'd0, 2'd1, 2'd2, 2'b01);
        tick();
        chk("t1_alu_a", alu_a, 81);
        chk("t1_alu_b", alu_b, 80);
        chk("t1_alu_cin", alu_cin, 1);
        chk("t1_ready_exec", in_ready, 0);
        in_valid = 1'b0;
        tick();
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_data", res_data, 162);
        chk("t1_res_cout", res_cout, 0);
        set_instr(2'd2, 2'd0, 2'd3, 2'b00);
        tick();
        chk("t1_r2_readback", alu_a, 162);
        in_valid = 1'b0;
        tick();
        chk("t1_second_res", res_data, 243);
        tick();
        chk("t1_idle_no_valid", res_valid, 0);

        // 2: carry out then carry chained through flag_c
        load(2'd0, 8'd200);
        load(2'd1, 8'd100);
        set_instr(2'd0, 2'd1, 2'd2, 2'b00);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2_res_data", res_data, 44);
        chk("t2_flag_c", flag_c, 1);
        set_instr(2'd0, 2'd1, 2'd3, 2'b10);
        tick();
        chk("t2_alu_cin", alu_cin, 1);
        in_valid = 1'b0;
        tick();
        chk("t2_res_data2", res_data, 45);
        tick();

        // 3: zero result
        load(2'd3, 8'd0);
        set_instr(2'd3, 2'd3, 2'd1, 2'b00);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_res_z", res_z, 1);
        chk("t3_flag_z", flag_z, 1);
        chk("t3_res_data", res_data, 0);
        tick();

        // 4: load forwarded into operand; load during EXEC is dropped
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'd7;
        set_instr(2'd1, 2'd3, 2'd0, 2'b00);
        tick();
        chk("t4_fwd_alu_a", alu_a, 7);
        in_valid = 1'b0; ld_data = 8'd99;
        tick();
        ld_en = 1'b0;
        chk("t4_res_data", res_data, 7);
        set_instr(2'd1, 2'd1, 2'd2, 2'b00);
        tick();
        chk("t4_r1_kept", alu_a, 7);
        in_valid = 1'b0;
        tick(); tick();

        // 5: back-to-back with in_valid held high
        pulses = 0; ready_low = 0;
        set_instr(2'd0, 2'd1, 2'd2, 2'b00);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (res_valid) pulses++;
            if (!in_ready) ready_low++;
        end
        in_valid = 1'b0;
        chk("t5_pulses", 32'(pulses), 3);
        chk("t5_ready_low", 32'(ready_low), 3);
        tick();

        // 6: reset in the middle of EXEC
        set_instr(2'd1, 2'd1, 2'd0, 2'b01);
        tick();
        chk("t6_busy", busy, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_alu_a_clr", alu_a, 0);
        chk("t6_busy_clr", busy, 0);
        chk("t6_ready", in_ready, 1);
        tick();
        chk("t6_no_valid", res_valid, 0);
        rst_n = 1'b1;
        set_instr(2'd1, 2'd0, 2'd3, 2'b00);
        tick();
        chk("t6_rf_cleared", alu_a, 0);
        in_valid = 1'b0;
        tick(); tick();

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 600; i++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = 4'($urandom);
            in_rd      = 2'($urandom);
            in_rs1     = 2'($urandom);
            in_rs2     = 2'($urandom);
            in_cin_sel = 2'($urandom);
            ld_en      = ($urandom_range(0, 2) == 0);
            ld_addr    = 2'($urandom);
            ld_data    = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            tick();
        end
        rst_n = 1'b1; in_valid = 1'b0; ld_en = 1'b0;
        tick(); tick();
        @(negedge clk);
        #1 stop_cmp = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
